// File: rtl/sha3_padder.sv
// SHA3 message padder: packs 64-bit words into rate blocks, applies DS suffix and pad10*1.
// Latency: block valid one edge after the completing word handshake; pad-only block follows with no bubble.
// Backpressure: single block buffer; IN_READY is low while a block is held awaiting BLOCK_READY.
module sha3_padder #(
  parameter int          R_BLOCK_SIZE = 1152,
  parameter logic [7:0]  DS           = 8'h06
) (
  input  logic                     CLK,
  input  logic                     A_RST_N,
  input  logic [63:0]              IN_DATA,
  input  logic [3:0]               IN_BYTES,
  input  logic                     IN_LAST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic [0:R_BLOCK_SIZE-1]  BLOCK_OUT,
  output logic                     BLOCK_VALID,
  output logic                     BLOCK_LAST,
  input  logic                     BLOCK_READY
);

  localparam int NW = R_BLOCK_SIZE / 64;
  localparam int NB = R_BLOCK_SIZE / 8;
  localparam int CW = $clog2(NW + 1);

  typedef enum logic {S_FILL, S_HOLD} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [NB-1:0][7:0]    r_buf;
  logic                  r_pad_pend;
  logic                  r_in_rdy;
  logic                  r_vld;
  logic                  r_last;

  logic                  w_acc;
  logic [3:0]            w_nb;
  logic [15:0]           w_n;
  logic [NB-1:0][7:0]    w_fill_buf;
  logic [NB-1:0][7:0]    w_pad_buf;

  assign w_acc = IN_VALID && r_in_rdy;

  // Valid byte count of the incoming word: full unless last, clamped to 8.
  always_comb begin
    w_nb = 4'd8;
    if (IN_LAST && (IN_BYTES < 4'd8)) begin
      w_nb = IN_BYTES;
    end
    w_n = (16'(r_cnt) * 16'd8) + 16'(w_nb);
  end

  // Buffer image after writing the current word, with padding if it ends the message inside this block.
  always_comb begin
    w_fill_buf = r_buf;
    for (int j = 0; j < 8; j++) begin
      w_fill_buf[int'(r_cnt) * 8 + j] = (4'(j) < w_nb) ? IN_DATA[8*j +: 8] : 8'h00;
    end
    if (IN_LAST && (w_n < 16'(NB))) begin
      w_fill_buf[w_n]    = w_fill_buf[w_n] ^ DS;
      w_fill_buf[NB-1]   = w_fill_buf[NB-1] ^ 8'h80;
    end
  end

  // Pad-only block used when the message ended exactly on a block boundary.
  always_comb begin
    w_pad_buf       = '0;
    w_pad_buf[0]    = DS;
    w_pad_buf[NB-1] = w_pad_buf[NB-1] ^ 8'h80;
  end

  // Fill/hold FSM; r_in_rdy doubles as the reset-release synchroniser (rises on first edge out of reset).
  always_ff @(posedge CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      r_state    <= S_FILL;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_pad_pend <= 1'b0;
      r_in_rdy   <= 1'b0;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          r_in_rdy <= 1'b1;
          if (w_acc) begin
            r_buf <= w_fill_buf;
            if (IN_LAST) begin
              r_state    <= S_HOLD;
              r_in_rdy   <= 1'b0;
              r_vld      <= 1'b1;
              r_cnt      <= '0;
              r_last     <= (w_n < 16'(NB));
              r_pad_pend <= (w_n == 16'(NB));
            end else if (r_cnt == CW'(NW - 1)) begin
              r_state  <= S_HOLD;
              r_in_rdy <= 1'b0;
              r_vld    <= 1'b1;
              r_cnt    <= '0;
              r_last   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (BLOCK_READY) begin
            if (r_pad_pend) begin
              r_buf      <= w_pad_buf;
              r_last     <= 1'b1;
              r_pad_pend <= 1'b0;
            end else begin
              r_buf    <= '0;
              r_vld    <= 1'b0;
              r_last   <= 1'b0;
              r_in_rdy <= 1'b1;
              r_state  <= S_FILL;
            end
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  assign IN_READY    = r_in_rdy;
  assign BLOCK_VALID = r_vld;
  assign BLOCK_LAST  = r_last;

  // Core bit order: byte k bit b lands at ascending index 8k+b.
  for (genvar k = 0; k < NB; k++) begin : g_byte
    for (genvar b = 0; b < 8; b++) begin : g_bit
      assign BLOCK_OUT[8*k + b] = r_buf[k][b];
    end
  end

endmodule

// File: tb/tb_sha3_padder.sv
module tb_sha3_padder;

  localparam int R  = 1152;
  localparam int NB = R / 8;

  typedef logic [0:R-1] blk_t;

  logic        CLK;
  logic        A_RST_N;
  logic [63:0] IN_DATA;
  logic [3:0]  IN_BYTES;
  logic        IN_LAST;
  logic        IN_VALID;
  logic        BLOCK_READY;

  logic        in_rdy_a, vld_a, last_a;
  blk_t        blk_a;
  logic        in_rdy_b, vld_b, last_b;
  blk_t        blk_b;

  sha3_padder #(.R_BLOCK_SIZE(R), .DS(8'h06)) u_dut (
    .CLK(CLK), .A_RST_N(A_RST_N), .IN_DATA(IN_DATA), .IN_BYTES(IN_BYTES),
    .IN_LAST(IN_LAST), .IN_VALID(IN_VALID), .IN_READY(in_rdy_a),
    .BLOCK_OUT(blk_a), .BLOCK_VALID(vld_a), .BLOCK_LAST(last_a), .BLOCK_READY(BLOCK_READY)
  );

  sha3_padder #(.R_BLOCK_SIZE(R), .DS(8'h01)) u_leg (
    .CLK(CLK), .A_RST_N(A_RST_N), .IN_DATA(IN_DATA), .IN_BYTES(IN_BYTES),
    .IN_LAST(IN_LAST), .IN_VALID(IN_VALID), .IN_READY(in_rdy_b),
    .BLOCK_OUT(blk_b), .BLOCK_VALID(vld_b), .BLOCK_LAST(last_b), .BLOCK_READY(BLOCK_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Expected blocks per instance (0: DS=06, 1: DS=01)
  blk_t exp_blk_a[$];
  logic exp_last_a[$];
  blk_t exp_blk_b[$];
  logic exp_last_b[$];

  // Captured handshakes
  int   hs_cnt[2];
  blk_t got_blk_a[0:63];
  logic got_last_a[0:63];
  int   hs_cyc_a[0:63];
  blk_t got_blk_b;
  logic got_last_b;
  int   cyc = 0;

  logic prev_vld[2];
  blk_t prev_blk[2];
  logic prev_last[2];
  logic prev_rdy;

  logic [7:0] msg [0:2*NB-1];

  task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [7:0] gb(input blk_t v, input int k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = v[8*k + b];
    return r;
  endfunction

  function automatic int first_diff(input blk_t a, input blk_t e);
    for (int k = 0; k < NB; k++) if (gb(a, k) != gb(e, k)) return k;
    return -1;
  endfunction

  // Model: pad the byte string as msg || DS || 0* with 0x80 in the final byte, cut into rate blocks.
  task automatic model_push(input int len);
    logic [7:0] pb [0:2*NB-1];
    logic [7:0] ds;
    int nblk;
    blk_t v;
    nblk = len / NB + 1;
    for (int d = 0; d < 2; d++) begin
      ds = (d == 0) ? 8'h06 : 8'h01;
      for (int i = 0; i < 2*NB; i++) pb[i] = (i < len) ? msg[i] : 8'h00;
      pb[len] = pb[len] ^ ds;
      pb[nblk*NB - 1] = pb[nblk*NB - 1] ^ 8'h80;
      for (int k = 0; k < nblk; k++) begin
        for (int j = 0; j < NB; j++)
          for (int b = 0; b < 8; b++) v[8*j + b] = pb[k*NB + j][b];
        if (d == 0) begin
          exp_blk_a.push_back(v); exp_last_a.push_back(k == nblk - 1);
        end else begin
          exp_blk_b.push_back(v); exp_last_b.push_back(k == nblk - 1);
        end
      end
    end
  endtask

  task automatic check_one(input int id);
    blk_t v_blk, e;
    logic v_vld, v_last, v_irdy, e_last;
    int d;
    v_blk  = (id == 0) ? blk_a : blk_b;
    v_vld  = (id == 0) ? vld_a : vld_b;
    v_last = (id == 0) ? last_a : last_b;
    v_irdy = (id == 0) ? in_rdy_a : in_rdy_b;
    if (prev_vld[id] && !prev_rdy) begin
      d = first_diff(v_blk, prev_blk[id]);
      chk(v_vld && (d < 0) && (v_last == prev_last[id]),
          $sformatf("hold_stable%0d", id), {v_vld, v_last}, {1'b1, prev_last[id]});
    end
    if (v_vld) chk(!v_irdy, $sformatf("in_ready_low_held%0d", id), v_irdy, 0);
    if (v_vld && BLOCK_READY) begin
      if (((id == 0) ? exp_blk_a.size() : exp_blk_b.size()) == 0) begin
        chk(1'b0, $sformatf("unexpected_block%0d", id), 1, 0);
      end else begin
        if (id == 0) begin
          e = exp_blk_a.pop_front(); e_last = exp_last_a.pop_front();
          got_blk_a[hs_cnt[0] % 64] = v_blk; got_last_a[hs_cnt[0] % 64] = v_last;
          hs_cyc_a[hs_cnt[0] % 64] = cyc;
        end else begin
          e = exp_blk_b.pop_front(); e_last = exp_last_b.pop_front();
          got_blk_b = v_blk; got_last_b = v_last;
        end
        hs_cnt[id]++;
        d = first_diff(v_blk, e);
        chk(d < 0, $sformatf("blk%0d_byte%0d", id, d), (d < 0) ? 0 : gb(v_blk, d), (d < 0) ? 0 : gb(e, d));
        chk(v_last == e_last, $sformatf("blk%0d_last", id), v_last, e_last);
      end
    end
    prev_vld[id] = v_vld; prev_blk[id] = v_blk; prev_last[id] = v_last;
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge CLK) begin
    if (!A_RST_N) begin
      prev_vld[0] = 1'b0; prev_vld[1] = 1'b0; prev_rdy = 1'b1;
    end else begin
      cyc++;
      check_one(0);
      check_one(1);
      prev_rdy = BLOCK_READY;
    end
  end

  task automatic send_word(input logic [63:0] dat, input logic [3:0] nb, input logic last);
    int k;
    IN_DATA = dat; IN_BYTES = nb; IN_LAST = last; IN_VALID = 1'b1;
    k = 0;
    while (!in_rdy_a && k < 200) begin @(posedge CLK); #1; k++; end
    chk(k < 200, "in_ready_wait", k, 200);
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_LAST = 1'b0;
  endtask

  task automatic send_msg(input int len, input logic [7:0] fill);
    int nw;
    logic [63:0] dat;
    int idx;
    model_push(len);
    nw = (len == 0) ? 1 : (len + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 8; j++) begin
        idx = 8*w + j;
        dat[8*j +: 8] = (idx < len) ? msg[idx] : fill;
      end
      send_word(dat, (w == nw - 1) ? 4'(len - 8*w) : 4'd8, w == nw - 1);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_blk_a.size() != 0 || vld_a) && k < 300) begin @(posedge CLK); #1; k++; end
    chk(k < 300, "drain_wait", k, 300);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    A_RST_N = 1'b0; IN_DATA = '0; IN_BYTES = '0; IN_LAST = 1'b0; IN_VALID = 1'b0;
    BLOCK_READY = 1'b1; hs_cnt[0] = 0; hs_cnt[1] = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk(!vld_a && !last_a && !in_rdy_a, "reset_ctrl", {vld_a, last_a, in_rdy_a}, 0);
    chk(blk_a == '0, "reset_blk", first_diff(blk_a, '0), -1);
    @(posedge CLK); #1; A_RST_N = 1'b1;
    @(negedge CLK);
    chk(!in_rdy_a, "in_ready_before_edge", in_rdy_a, 0);
    @(posedge CLK); #1;
    chk(in_rdy_a, "in_ready_after_release", in_rdy_a, 1);

    // Legacy Keccak vector on the DS=01 instance
    msg[0] = 8'h53; msg[1] = 8'h58; msg[2] = 8'h7B; msg[3] = 8'h99;
    send_msg(4, 8'h00);
    wait_drain();
    chk(gb(got_blk_b, 0) == 8'h53 && gb(got_blk_b, 1) == 8'h58 && gb(got_blk_b, 2) == 8'h7B &&
        gb(got_blk_b, 3) == 8'h99, "legacy_data", {gb(got_blk_b,0), gb(got_blk_b,1), gb(got_blk_b,2), gb(got_blk_b,3)}, 32'h53587B99);
    chk(gb(got_blk_b, 4) == 8'h01, "legacy_ds", gb(got_blk_b, 4), 8'h01);
    chk(gb(got_blk_b, 5) == 8'h00 && gb(got_blk_b, 142) == 8'h00, "legacy_zero", gb(got_blk_b, 5), 0);
    chk(gb(got_blk_b, 143) == 8'h80 && got_last_b, "legacy_end", gb(got_blk_b, 143), 8'h80);

    // Empty message
    send_msg(0, 8'hA5);
    wait_drain();
    h = (hs_cnt[0] - 1) % 64;
    chk(gb(got_blk_a[h], 0) == 8'h06, "empty_b0", gb(got_blk_a[h], 0), 8'h06);
    chk(gb(got_blk_a[h], 143) == 8'h80 && gb(got_blk_a[h], 1) == 8'h00, "empty_b143", gb(got_blk_a[h], 143), 8'h80);
    chk(got_last_a[h], "empty_last", got_last_a[h], 1);

    // 143-byte message
    for (int i = 0; i < 2*NB; i++) msg[i] = 8'(i);
    send_msg(143, 8'h5A);
    wait_drain();
    h = (hs_cnt[0] - 1) % 64;
    chk(gb(got_blk_a[h], 142) == 8'h8E, "m143_b142", gb(got_blk_a[h], 142), 8'h8E);
    chk(gb(got_blk_a[h], 143) == 8'h86, "m143_b143", gb(got_blk_a[h], 143), 8'h86);

    // 144-byte message: data block then pad-only block back to back
    h = hs_cnt[0];
    send_msg(144, 8'h5A);
    wait_drain();
    chk(hs_cnt[0] - h == 2, "m144_blocks", hs_cnt[0] - h, 2);
    chk(!got_last_a[h % 64] && got_last_a[(h+1) % 64], "m144_last", {got_last_a[h % 64], got_last_a[(h+1) % 64]}, 2'b01);
    chk(hs_cyc_a[(h+1) % 64] - hs_cyc_a[h % 64] == 1, "m144_no_bubble", hs_cyc_a[(h+1) % 64] - hs_cyc_a[h % 64], 1);
    chk(gb(got_blk_a[h % 64], 143) == 8'h8F, "m144_b143", gb(got_blk_a[h % 64], 143), 8'h8F);
    chk(gb(got_blk_a[(h+1) % 64], 0) == 8'h06, "m144_pad_b0", gb(got_blk_a[(h+1) % 64], 0), 8'h06);

    // Backpressure: ten cycles of BLOCK_READY low
    BLOCK_READY = 1'b0;
    for (int i = 0; i < 20; i++) msg[i] = 8'(8'hC0 + i);
    send_msg(20, 8'hFF);
    chk(vld_a, "bp_valid_rise", vld_a, 1);
    repeat (10) @(posedge CLK);
    #1;
    h = hs_cnt[0];
    chk(vld_a && !in_rdy_a, "bp_still_held", {vld_a, in_rdy_a}, 2'b10);
    BLOCK_READY = 1'b1;
    wait_drain();
    chk(hs_cnt[0] - h == 1, "bp_one_handshake", hs_cnt[0] - h, 1);

    // Other lengths: two-word, n = NB-2
    for (int i = 0; i < 2*NB; i++) msg[i] = 8'(8'h3C ^ i);
    send_msg(9, 8'h77);
    send_msg(142, 8'h77);
    wait_drain();

    // IN_BYTES above 8 on the last word acts as 8
    for (int i = 0; i < 8; i++) msg[i] = 8'(8'h10 + i);
    model_push(8);
    send_word(64'h1716_1514_1312_1110, 4'hC, 1'b1);
    wait_drain();

    // Reset mid-fill
    for (int i = 0; i < 5; i++) send_word(64'hDEAD_BEEF_0000_0000 | 64'(i), 4'd8, 1'b0);
    #2; A_RST_N = 1'b0; #1;
    chk(!vld_a && !last_a && !in_rdy_a, "midrst_ctrl", {vld_a, last_a, in_rdy_a}, 0);
    chk(blk_a == '0, "midrst_blk", first_diff(blk_a, '0), -1);
    @(posedge CLK); #1; A_RST_N = 1'b1;
    @(posedge CLK); #1;
    h = hs_cnt[0];
    send_msg(0, 8'h00);
    wait_drain();
    chk(hs_cnt[0] - h == 1, "midrst_one_block", hs_cnt[0] - h, 1);
    chk(gb(got_blk_a[h % 64], 0) == 8'h06 && gb(got_blk_a[h % 64], 8) == 8'h00, "midrst_pad_only", gb(got_blk_a[h % 64], 8), 0);
    repeat (5) @(posedge CLK);
    #1;
    chk(exp_blk_b.size() == 0, "leg_queue_empty", exp_blk_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
